// File: rtl/microarquitectura.sv
// Single-cycle RV32I-subset core: ROM fetch, 32x32 register file, ALU,
// branch unit, byte-laned data memory DM and the OutGPIO output register.

module microarquitectura_dmem (
    input  logic        clk,
    input  logic [29:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o
);
    logic [7:0]        RAM [0:3][-64:64];
    logic              in_range_s;
    logic signed [7:0] widx_s;

    assign in_range_s = ($signed(waddr_i) >= -30'sd64) && ($signed(waddr_i) <= 30'sd64);
    // An 8-bit signed index is exact for -64..64 once the range check passes
    assign widx_s     = waddr_i[7:0];

    // Lane-enabled store; memory has no reset so contents survive it
    always_ff @(posedge clk) begin
        if (in_range_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    RAM[k][widx_s] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Combinational word read, zero outside the populated range
    always_comb begin
        if (in_range_s) begin
            rdata_o = {RAM[3][widx_s], RAM[2][widx_s], RAM[1][widx_s], RAM[0][widx_s]};
        end else begin
            rdata_o = 32'd0;
        end
    end
endmodule

module microarquitectura #(
    parameter int          IMEM_WORDS = 256,
    parameter string       IMEM_FILE  = "program.txt",
    parameter logic [31:0] GPIO_ADDR  = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] OutGPIO
);
    localparam int          IMEM_AW   = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;

    logic [31:0] imem_q [IMEM_WORDS];
    logic [31:0] rf_q   [32];
    logic [31:0] pc_q, pc_d, gpio_q, gpio_d;
    logic [31:0] instr_s, rs1_val_s, rs2_val_s, pc_plus4_s, mem_addr_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] rd_wdata_s, dm_wdata_s, dm_rdata_s, ld_word_s;
    logic [6:0]  opcode_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  funct3_s;
    logic [3:0]  dm_be_s;
    logic        rd_we_s;

    function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic branch_fn(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] load_fn(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] word);
        logic [31:0] sh;
        logic [15:0] h;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        h  = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, sh[7:0]};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Fetch, with a nop beyond the end of the ROM
    always_comb begin
        if ({2'b00, pc_q[31:2]} < 32'(IMEM_WORDS)) begin
            instr_s = imem_q[pc_q[IMEM_AW+1:2]];
        end else begin
            instr_s = NOP;
        end
    end

    assign opcode_s   = instr_s[6:0];
    assign rd_s       = instr_s[11:7];
    assign funct3_s   = instr_s[14:12];
    assign rs1_s      = instr_s[19:15];
    assign rs2_s      = instr_s[24:20];
    assign imm_i_s    = {{20{instr_s[31]}}, instr_s[31:20]};
    assign imm_s_s    = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign imm_b_s    = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
    assign imm_u_s    = {instr_s[31:12], 12'd0};
    assign imm_j_s    = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
    assign rs1_val_s  = (rs1_s == 5'd0) ? 32'd0 : rf_q[rs1_s];
    assign rs2_val_s  = (rs2_s == 5'd0) ? 32'd0 : rf_q[rs2_s];
    assign pc_plus4_s = pc_q + 32'd4;
    assign mem_addr_s = rs1_val_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
    assign ld_word_s  = (mem_addr_s == GPIO_ADDR) ? gpio_q : dm_rdata_s;

    // Execute: next PC, register writeback, store lanes and GPIO update
    always_comb begin
        pc_d       = pc_plus4_s;
        gpio_d     = gpio_q;
        rd_we_s    = 1'b0;
        rd_wdata_s = 32'd0;
        dm_be_s    = 4'b0000;
        dm_wdata_s = 32'd0;
        case (opcode_s)
            OP_LUI: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = imm_u_s;
            end
            OP_AUIPC: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_q + imm_u_s;
            end
            OP_JAL: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_plus4_s;
                pc_d       = pc_q + imm_j_s;
            end
            OP_JALR: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_plus4_s;
                pc_d       = {mem_addr_s[31:1], 1'b0};
            end
            OP_BRANCH: begin
                if (branch_fn(funct3_s, rs1_val_s, rs2_val_s)) begin
                    pc_d = pc_q + imm_b_s;
                end else begin
                    pc_d = pc_plus4_s;
                end
            end
            OP_LOAD: begin
                rd_we_s    = (funct3_s != 3'b011) && (funct3_s[2:1] != 2'b11);
                rd_wdata_s = load_fn(funct3_s, mem_addr_s[1:0], ld_word_s);
            end
            OP_STORE: begin
                if (mem_addr_s == GPIO_ADDR) begin
                    if (funct3_s == 3'b010) begin
                        gpio_d = rs2_val_s;
                    end else begin
                        gpio_d = gpio_q;
                    end
                end else begin
                    case (funct3_s)
                        3'b000: begin
                            dm_be_s    = 4'b0001 << mem_addr_s[1:0];
                            dm_wdata_s = {4{rs2_val_s[7:0]}};
                        end
                        3'b001: begin
                            dm_be_s    = mem_addr_s[1] ? 4'b1100 : 4'b0011;
                            dm_wdata_s = {2{rs2_val_s[15:0]}};
                        end
                        3'b010: begin
                            dm_be_s    = 4'b1111;
                            dm_wdata_s = rs2_val_s;
                        end
                        default: dm_be_s = 4'b0000;
                    endcase
                end
            end
            OP_IMM: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = alu_fn(funct3_s, (funct3_s == 3'b101) & instr_s[30], rs1_val_s, imm_i_s);
            end
            OP_REG: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = alu_fn(funct3_s, instr_s[30], rs1_val_s, rs2_val_s);
            end
            default: pc_d = pc_plus4_s;
        endcase
    end

    // Stores are suppressed while reset holds the core
    microarquitectura_dmem DM (
        .clk     (clk),
        .waddr_i (mem_addr_s[31:2]),
        .wdata_i (dm_wdata_s),
        .be_i    (dm_be_s & {4{reset}}),
        .rdata_o (dm_rdata_s)
    );

    // Architectural state: PC, GPIO and register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= 32'd0;
            gpio_q <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            pc_q   <= pc_d;
            gpio_q <= gpio_d;
            if (rd_we_s && (rd_s != 5'd0)) begin
                rf_q[rd_s] <= rd_wdata_s;
            end
        end
    end

    assign OutGPIO = gpio_q;
endmodule

// File: tb/tb_microarquitectura.sv
// Directed-program bench for the single-cycle core: each task loads a short
// program, runs a fixed number of cycles and checks architectural state.

module tb_microarquitectura;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;
    localparam logic [6:0]  OP_IMM  = 7'b0010011;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] gpio;
    logic [31:0] prog [$];
    int          n_checks = 0;
    int          n_fail = 0;

    microarquitectura dut (
        .clk     (clk),
        .reset   (reset),
        .OutGPIO (gpio)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    task automatic start_prog();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            dut.imem_q[i[7:0]] = (i < prog.size()) ? prog[i] : NOP;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (dut.pc_q !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", dut.pc_q, 32'd0); end
        n_checks++; if (gpio !== 32'd0) begin n_fail++; $display("FAIL reset_gpio: got %h want %h", gpio, 32'd0); end
        prog = '{enc_i(12'd5, 5'd0, 3'b000, 5'd5, OP_IMM),
                 enc_i(12'hFFD, 5'd0, 3'b000, 5'd6, OP_IMM),
                 enc_r(7'h00, 5'd6, 5'd5, 3'b000, 5'd7)};
        n_checks++; if (prog[0] !== 32'h0050_0293) begin n_fail++; $display("FAIL enc_addi: got %h want %h", prog[0], 32'h0050_0293); end
        start_prog();
        run(3);
        n_checks++; if (dut.rf_q[6] !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL basic_x6: got %h want %h", dut.rf_q[6], 32'hFFFF_FFFD); end
        n_checks++; if (dut.rf_q[7] !== 32'd2) begin n_fail++; $display("FAIL basic_x7: got %h want %h", dut.rf_q[7], 32'd2); end
        n_checks++; if (dut.pc_q !== 32'd12) begin n_fail++; $display("FAIL basic_pc: got %h want %h", dut.pc_q, 32'd12); end
        reset = 1'b0;
        #1;
        n_checks++; if (dut.pc_q !== 32'd0) begin n_fail++; $display("FAIL async_pc: got %h want %h", dut.pc_q, 32'd0); end
        n_checks++; if (dut.rf_q[7] !== 32'd0) begin n_fail++; $display("FAIL async_x7: got %h want %h", dut.rf_q[7], 32'd0); end
        @(negedge clk);
        reset = 1'b1;
        run(2);
        n_checks++; if (dut.rf_q[7] !== 32'd0) begin n_fail++; $display("FAIL restart_x7_early: got %h want %h", dut.rf_q[7], 32'd0); end
        run(1);
        n_checks++; if (dut.rf_q[7] !== 32'd2) begin n_fail++; $display("FAIL restart_x7: got %h want %h", dut.rf_q[7], 32'd2); end
    endtask

    task automatic test_stack();
        prog = '{enc_i(12'hFF0, 5'd2, 3'b000, 5'd2, OP_IMM),
                 enc_i(12'h07B, 5'd0, 3'b000, 5'd5, OP_IMM),
                 enc_s(12'd12, 5'd5, 5'd2, 3'b010),
                 enc_i(12'd12, 5'd2, 3'b010, 5'd6, OP_LOAD)};
        start_prog();
        run(4);
        n_checks++; if (dut.rf_q[2] !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL stack_sp: got %h want %h", dut.rf_q[2], 32'hFFFF_FFF0); end
        n_checks++; if (dut.DM.RAM[0][-1] !== 8'h7B) begin n_fail++; $display("FAIL stack_ram0: got %h want %h", dut.DM.RAM[0][-1], 8'h7B); end
        n_checks++; if (dut.DM.RAM[1][-1] !== 8'h00) begin n_fail++; $display("FAIL stack_ram1: got %h want %h", dut.DM.RAM[1][-1], 8'h00); end
        n_checks++; if (dut.DM.RAM[2][-1] !== 8'h00) begin n_fail++; $display("FAIL stack_ram2: got %h want %h", dut.DM.RAM[2][-1], 8'h00); end
        n_checks++; if (dut.DM.RAM[3][-1] !== 8'h00) begin n_fail++; $display("FAIL stack_ram3: got %h want %h", dut.DM.RAM[3][-1], 8'h00); end
        n_checks++; if (dut.rf_q[6] !== 32'h0000_007B) begin n_fail++; $display("FAIL stack_lw: got %h want %h", dut.rf_q[6], 32'h0000_007B); end
        prog = '{NOP};
        start_prog();
        run(1);
        n_checks++; if (dut.DM.RAM[0][-1] !== 8'h7B) begin n_fail++; $display("FAIL dm_persist: got %h want %h", dut.DM.RAM[0][-1], 8'h7B); end
        n_checks++; if (dut.rf_q[6] !== 32'd0) begin n_fail++; $display("FAIL reg_cleared: got %h want %h", dut.rf_q[6], 32'd0); end
    endtask

    task automatic test_lanes();
        prog = '{enc_s(12'd0, 5'd0, 5'd0, 3'b010),
                 enc_i(12'h080, 5'd0, 3'b000, 5'd5, OP_IMM),
                 enc_s(12'd1, 5'd5, 5'd0, 3'b000),
                 {20'h0000C, 5'd6, 7'b0110111},
                 enc_i(12'hEEF, 5'd6, 3'b000, 5'd6, OP_IMM),
                 enc_s(12'd2, 5'd6, 5'd0, 3'b001),
                 enc_i(12'd1, 5'd0, 3'b000, 5'd7, OP_LOAD),
                 enc_i(12'd1, 5'd0, 3'b100, 5'd8, OP_LOAD),
                 enc_i(12'd2, 5'd0, 3'b001, 5'd9, OP_LOAD),
                 enc_i(12'd2, 5'd0, 3'b101, 5'd10, OP_LOAD),
                 enc_i(12'd0, 5'd0, 3'b010, 5'd11, OP_LOAD),
                 enc_s(12'd260, 5'd5, 5'd0, 3'b010),
                 enc_i(12'd260, 5'd0, 3'b010, 5'd12, OP_LOAD),
                 enc_s(12'd256, 5'd6, 5'd0, 3'b010),
                 enc_i(12'd256, 5'd0, 3'b010, 5'd13, OP_LOAD)};
        start_prog();
        run(15);
        n_checks++; if (dut.DM.RAM[3][0] !== 8'hBE) begin n_fail++; $display("FAIL lane3: got %h want %h", dut.DM.RAM[3][0], 8'hBE); end
        n_checks++; if (dut.DM.RAM[2][0] !== 8'hEF) begin n_fail++; $display("FAIL lane2: got %h want %h", dut.DM.RAM[2][0], 8'hEF); end
        n_checks++; if (dut.DM.RAM[1][0] !== 8'h80) begin n_fail++; $display("FAIL lane1: got %h want %h", dut.DM.RAM[1][0], 8'h80); end
        n_checks++; if (dut.DM.RAM[0][0] !== 8'h00) begin n_fail++; $display("FAIL lane0: got %h want %h", dut.DM.RAM[0][0], 8'h00); end
        n_checks++; if (dut.rf_q[7] !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb: got %h want %h", dut.rf_q[7], 32'hFFFF_FF80); end
        n_checks++; if (dut.rf_q[8] !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu: got %h want %h", dut.rf_q[8], 32'h0000_0080); end
        n_checks++; if (dut.rf_q[9] !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL lh: got %h want %h", dut.rf_q[9], 32'hFFFF_BEEF); end
        n_checks++; if (dut.rf_q[10] !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu: got %h want %h", dut.rf_q[10], 32'h0000_BEEF); end
        n_checks++; if (dut.rf_q[11] !== 32'hBEEF_8000) begin n_fail++; $display("FAIL lw_word0: got %h want %h", dut.rf_q[11], 32'hBEEF_8000); end
        n_checks++; if (dut.rf_q[12] !== 32'd0) begin n_fail++; $display("FAIL oor_load: got %h want %h", dut.rf_q[12], 32'd0); end
        n_checks++; if (dut.rf_q[13] !== 32'h0000_BEEF) begin n_fail++; $display("FAIL top_word: got %h want %h", dut.rf_q[13], 32'h0000_BEEF); end
        n_checks++; if (dut.DM.RAM[0][64] !== 8'hEF) begin n_fail++; $display("FAIL top_lane0: got %h want %h", dut.DM.RAM[0][64], 8'hEF); end
    endtask

    task automatic test_loop();
        prog = '{enc_i(12'd10, 5'd0, 3'b000, 5'd6, OP_IMM),
                 enc_i(12'd1, 5'd5, 3'b000, 5'd5, OP_IMM),
                 enc_b(13'h1FFC, 5'd6, 5'd5, 3'b001),
                 enc_s(12'h400, 5'd5, 5'd0, 3'b010),
                 enc_s(12'h400, 5'd6, 5'd0, 3'b000),
                 enc_i(12'h400, 5'd0, 3'b010, 5'd7, OP_LOAD)};
        start_prog();
        run(21);
        n_checks++; if (gpio !== 32'd0) begin n_fail++; $display("FAIL loop_gpio_early: got %h want %h", gpio, 32'd0); end
        n_checks++; if (dut.pc_q !== 32'd12) begin n_fail++; $display("FAIL loop_exit_pc: got %h want %h", dut.pc_q, 32'd12); end
        run(1);
        n_checks++; if (gpio !== 32'd10) begin n_fail++; $display("FAIL loop_gpio: got %h want %h", gpio, 32'd10); end
        n_checks++; if (dut.pc_q !== 32'd16) begin n_fail++; $display("FAIL loop_pc: got %h want %h", dut.pc_q, 32'd16); end
        run(2);
        n_checks++; if (gpio !== 32'd10) begin n_fail++; $display("FAIL gpio_sb_ignored: got %h want %h", gpio, 32'd10); end
        n_checks++; if (dut.rf_q[7] !== 32'd10) begin n_fail++; $display("FAIL gpio_load: got %h want %h", dut.rf_q[7], 32'd10); end
    endtask

    task automatic test_jump();
        prog = '{enc_i(12'd7, 5'd0, 3'b000, 5'd0, OP_IMM),
                 enc_j(21'd8, 5'd1),
                 enc_i(12'd1, 5'd0, 3'b000, 5'd5, OP_IMM),
                 enc_i(12'd0, 5'd1, 3'b000, 5'd0, OP_JALR)};
        start_prog();
        run(2);
        n_checks++; if (dut.pc_q !== 32'd12) begin n_fail++; $display("FAIL jal_pc: got %h want %h", dut.pc_q, 32'd12); end
        n_checks++; if (dut.rf_q[1] !== 32'd8) begin n_fail++; $display("FAIL jal_link: got %h want %h", dut.rf_q[1], 32'd8); end
        run(1);
        n_checks++; if (dut.pc_q !== 32'd8) begin n_fail++; $display("FAIL jalr_pc: got %h want %h", dut.pc_q, 32'd8); end
        n_checks++; if (dut.rf_q[0] !== 32'd0) begin n_fail++; $display("FAIL x0_zero: got %h want %h", dut.rf_q[0], 32'd0); end
        run(1);
        n_checks++; if (dut.rf_q[5] !== 32'd1) begin n_fail++; $display("FAIL ret_body: got %h want %h", dut.rf_q[5], 32'd1); end
        prog = '{enc_i(12'd13, 5'd0, 3'b000, 5'd3, OP_IMM),
                 enc_i(12'd0, 5'd3, 3'b000, 5'd3, OP_JALR)};
        start_prog();
        run(2);
        n_checks++; if (dut.pc_q !== 32'd12) begin n_fail++; $display("FAIL jalr_bit0: got %h want %h", dut.pc_q, 32'd12); end
        n_checks++; if (dut.rf_q[3] !== 32'd8) begin n_fail++; $display("FAIL jalr_same_reg: got %h want %h", dut.rf_q[3], 32'd8); end
    endtask

    task automatic test_alu();
        prog = '{enc_i(12'hFF8, 5'd0, 3'b000, 5'd5, OP_IMM),
                 enc_i(12'h401, 5'd5, 3'b101, 5'd6, OP_IMM),
                 enc_i(12'd28, 5'd5, 3'b101, 5'd7, OP_IMM),
                 enc_r(7'h00, 5'd0, 5'd5, 3'b010, 5'd8),
                 enc_r(7'h00, 5'd5, 5'd0, 3'b011, 5'd9),
                 enc_r(7'h20, 5'd5, 5'd0, 3'b000, 5'd10),
                 {20'h00001, 5'd11, 7'b0010111},
                 32'h0000_0073,
                 enc_r(7'h00, 5'd10, 5'd10, 3'b001, 5'd12)};
        start_prog();
        run(9);
        n_checks++; if (dut.rf_q[6] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL srai: got %h want %h", dut.rf_q[6], 32'hFFFF_FFFC); end
        n_checks++; if (dut.rf_q[7] !== 32'h0000_000F) begin n_fail++; $display("FAIL srli: got %h want %h", dut.rf_q[7], 32'h0000_000F); end
        n_checks++; if (dut.rf_q[8] !== 32'd1) begin n_fail++; $display("FAIL slt: got %h want %h", dut.rf_q[8], 32'd1); end
        n_checks++; if (dut.rf_q[9] !== 32'd1) begin n_fail++; $display("FAIL sltu: got %h want %h", dut.rf_q[9], 32'd1); end
        n_checks++; if (dut.rf_q[10] !== 32'd8) begin n_fail++; $display("FAIL sub: got %h want %h", dut.rf_q[10], 32'd8); end
        n_checks++; if (dut.rf_q[11] !== 32'h0000_1018) begin n_fail++; $display("FAIL auipc: got %h want %h", dut.rf_q[11], 32'h0000_1018); end
        n_checks++; if (dut.rf_q[12] !== 32'h0000_0800) begin n_fail++; $display("FAIL sll: got %h want %h", dut.rf_q[12], 32'h0000_0800); end
        n_checks++; if (dut.pc_q !== 32'd36) begin n_fail++; $display("FAIL ecall_nop_pc: got %h want %h", dut.pc_q, 32'd36); end
    endtask

    initial begin
        test_reset();
        test_stack();
        test_lanes();
        test_loop();
        test_jump();
        test_alu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
